// File: rtl/gamepad_pmod_tx.sv
// -----------------------------------------------------------------------------
// gamepad_pmod_tx
//   Serial transmitter for the Gamepad Pmod 3-wire protocol (data, clk, latch).
//   A parallel button word is shifted out MSB first. Each bit is presented with
//   pmod_clk low and is held stable through the following pmod_clk high phase,
//   so the receiver samples it on the pmod_clk rising edge. After the last bit
//   a single latch pulse transfers the word into the receiver's data register.
//   A fixed idle gap follows before the next frame may start.
//
// Optional feature (compile-time macro GAMEPAD_PMOD_TX_AUTO_EN):
//   auto-repeat. When the macro is defined the last captured word (all 1s after
//   reset) is re-sent continuously. A valid word offered during the single IDLE
//   cycle between frames replaces it. Without the macro, one frame is sent per
//   accepted word.
//
// Parameters:
//   BIT_WIDTH  - bits per frame (>= 2)
//   CLK_DIV    - system clocks per pmod_clk half-period (>= 2)
//   GAP_CYCLES - idle clocks after the latch pulse (>= 1)
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   i_data_in     in   word to send, bit BIT_WIDTH-1 first
//   i_in_valid    in   i_data_in is valid
//   o_in_ready    out  transmitter can accept a word (state IDLE)
//   o_pmod_data   out  serial data
//   o_pmod_clk    out  serial clock
//   o_pmod_latch  out  frame latch, rising edge marks end of frame
//   o_busy        out  a frame is in progress
//   o_frame_done  out  one-cycle pulse on the final gap cycle of a frame
// -----------------------------------------------------------------------------
module gamepad_pmod_tx #(
   parameter int BIT_WIDTH  = 24,
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BIT_WIDTH-1:0] i_data_in,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   output logic                 o_pmod_data,
   output logic                 o_pmod_clk,
   output logic                 o_pmod_latch,
   output logic                 o_busy,
   output logic                 o_frame_done
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(BIT_WIDTH);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LATCH_SETUP,
      S_LATCH_HI,
      S_GAP
   } state_t;

   state_t               r_state;
   logic [DIV_W-1:0]     r_div;
   logic [BIT_W-1:0]     r_bit;
   logic [GAP_W-1:0]     r_gap;
   // Holds the bits still to be sent; the bit currently on the wire lives in
   // r_pmod_data, so only BIT_WIDTH-1 bits need storing.
   logic [BIT_WIDTH-2:0] r_shift;
   logic                 r_pmod_data;
   logic                 r_pmod_clk;
   logic                 r_pmod_latch;
   logic                 r_busy;
   logic                 r_in_ready;
   logic                 r_frame_done;

   logic                 w_start;
   logic [BIT_WIDTH-1:0] w_word;
   logic                 w_div_end;

`ifdef GAMEPAD_PMOD_TX_AUTO_EN
   logic [BIT_WIDTH-1:0] r_hold;

   // Every IDLE cycle starts a frame; a fresh valid word overrides the held one.
   assign w_start = 1'b1;
   assign w_word  = i_in_valid ? i_data_in : r_hold;
`else
   assign w_start = i_in_valid;
   assign w_word  = i_data_in;
`endif

   assign w_div_end = (r_div == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_div        <= '0;
         r_bit        <= '0;
         r_gap        <= '0;
         r_shift      <= '0;
         r_pmod_data  <= 1'b0;
         r_pmod_clk   <= 1'b0;
         r_pmod_latch <= 1'b0;
         r_busy       <= 1'b0;
         r_in_ready   <= 1'b1;
         r_frame_done <= 1'b0;
`ifdef GAMEPAD_PMOD_TX_AUTO_EN
         r_hold       <= '1;
`endif
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_shift     <= w_word[BIT_WIDTH-2:0];
                  r_pmod_data <= w_word[BIT_WIDTH-1];
                  r_bit       <= BIT_LAST;
                  r_div       <= '0;
                  r_busy      <= 1'b1;
                  r_in_ready  <= 1'b0;
                  r_state     <= S_SHIFT_LO;
`ifdef GAMEPAD_PMOD_TX_AUTO_EN
                  r_hold      <= w_word;
`endif
               end
            end

            S_SHIFT_LO: begin
               if (w_div_end) begin
                  r_div      <= '0;
                  r_pmod_clk <= 1'b1;
                  r_state    <= S_SHIFT_HI;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end

            // Data only moves on the falling pmod_clk transition, so it is
            // never disturbed while the receiver may be sampling.
            S_SHIFT_HI: begin
               if (w_div_end) begin
                  r_div      <= '0;
                  r_pmod_clk <= 1'b0;
                  if (r_bit == '0) begin
                     r_pmod_data <= 1'b0;
                     r_state     <= S_LATCH_SETUP;
                  end else begin
                     r_bit       <= r_bit - BIT_W'(1);
                     r_pmod_data <= r_shift[BIT_WIDTH-2];
                     r_shift     <= r_shift << 1;
                     r_state     <= S_SHIFT_LO;
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end

            S_LATCH_SETUP: begin
               if (w_div_end) begin
                  r_div        <= '0;
                  r_pmod_latch <= 1'b1;
                  r_state      <= S_LATCH_HI;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end

            // frame_done is registered one cycle ahead so it is high exactly
            // during the last gap cycle; with a one-cycle gap that means
            // raising it on the way into GAP.
            S_LATCH_HI: begin
               if (w_div_end) begin
                  r_div        <= '0;
                  r_pmod_latch <= 1'b0;
                  r_gap        <= GAP_LAST;
                  r_frame_done <= (GAP_LAST == '0);
                  r_state      <= S_GAP;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end

            S_GAP: begin
               if (r_gap == '0) begin
                  r_busy     <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_state    <= S_IDLE;
               end else begin
                  r_gap        <= r_gap - GAP_W'(1);
                  r_frame_done <= (r_gap == GAP_W'(1));
               end
            end

            default: begin
               r_pmod_data  <= 1'b0;
               r_pmod_clk   <= 1'b0;
               r_pmod_latch <= 1'b0;
               r_busy       <= 1'b0;
               r_in_ready   <= 1'b1;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready   = r_in_ready;
   assign o_pmod_data  = r_pmod_data;
   assign o_pmod_clk   = r_pmod_clk;
   assign o_pmod_latch = r_pmod_latch;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

endmodule
